// File: rtl/wb_gpio_slave.sv
// Wishbone classic slave for a GPIO block: IN/OUT/DIR/IE/IS registers,
// 2-flop input synchronizer, rising-edge interrupt status and a level IRQ.
module wb_gpio_slave #(
    parameter int GPIO_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    output logic              wb_ack_o,
    input  logic [GPIO_W-1:0] gpio_i,
    output logic [GPIO_W-1:0] gpio_o,
    output logic [GPIO_W-1:0] gpio_oe_o,
    output logic              irq_o,
    output logic              dbg_state
);

    // Handshake: a request (stb & cyc) is sampled only in IDLE; the slave
    // answers with exactly one ack cycle (ACK state) and never samples
    // requests while acking, so a held strobe yields one transfer per 2 cycles.
    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    localparam logic [2:0] ADR_IN  = 3'd0;
    localparam logic [2:0] ADR_OUT = 3'd1;
    localparam logic [2:0] ADR_DIR = 3'd2;
    localparam logic [2:0] ADR_IE  = 3'd3;
    localparam logic [2:0] ADR_IS  = 3'd4;

    state_t            state, state_nxt;
    logic              accept;
    logic              wr_en;
    logic [2:0]        reg_adr;
    logic [31:0]       lane_mask;
    logic [31:0]       rd_data;
    logic [31:0]       dat_q;
    logic [GPIO_W-1:0] out_q, dir_q, ie_q, is_q, is_nxt, is_clr, rise;
    logic [GPIO_W-1:0] sync1, sync2, prev;
    logic              irq_q;
    logic              unused_adr;

    assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};
    assign reg_adr    = wb_adr_i[4:2];
    assign lane_mask  = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                         {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

    function automatic logic [GPIO_W-1:0] merge_lanes(
        input logic [GPIO_W-1:0] old_v,
        input logic [31:0]       new_v,
        input logic [31:0]       mask
    );
        logic [31:0] old32;
        old32 = 32'(old_v);
        return GPIO_W'((old32 & ~mask) | (new_v & mask));
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (wb_stb_i && wb_cyc_i) begin
                    accept    = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_en = accept && wb_we_i;

    always_comb begin
        rd_data = '0;
        case (reg_adr)
            ADR_IN:  rd_data = 32'(sync2);
            ADR_OUT: rd_data = 32'(out_q);
            ADR_DIR: rd_data = 32'(dir_q);
            ADR_IE:  rd_data = 32'(ie_q);
            ADR_IS:  rd_data = 32'(is_q);
            default: rd_data = '0;
        endcase
    end

    // Edge set wins over a W1C clear landing on the same bit in the same cycle.
    assign rise   = sync2 & ~prev;
    assign is_clr = (wr_en && reg_adr == ADR_IS) ? GPIO_W'(wb_dat_i & lane_mask) : '0;
    assign is_nxt = (is_q & ~is_clr) | rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            out_q <= '0;
            dir_q <= '0;
            ie_q  <= '0;
            is_q  <= '0;
            irq_q <= 1'b0;
            dat_q <= '0;
        end else begin
            sync1 <= gpio_i;
            sync2 <= sync1;
            prev  <= sync2;
            is_q  <= is_nxt;
            irq_q <= |(is_q & ie_q);
            dat_q <= (accept && !wb_we_i) ? rd_data : 32'd0;
            if (wr_en) begin
                case (reg_adr)
                    ADR_OUT: out_q <= merge_lanes(out_q, wb_dat_i, lane_mask);
                    ADR_DIR: dir_q <= merge_lanes(dir_q, wb_dat_i, lane_mask);
                    ADR_IE:  ie_q  <= merge_lanes(ie_q, wb_dat_i, lane_mask);
                    default: ;
                endcase
            end
        end
    end

    assign wb_ack_o  = (state == ACK);
    assign wb_dat_o  = dat_q;
    assign gpio_o    = out_q;
    assign gpio_oe_o = dir_q;
    assign irq_o     = irq_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_wb_gpio_slave.sv
// Directed bench for wb_gpio_slave: register table plus hand sequences for
// synchronizer latency, W1C/edge races, back-to-back strobes and reset abort.
module tb_wb_gpio_slave;

    logic        clk, rst;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic        wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o;
    logic [3:0]  wb_sel_i;
    logic [31:0] gpio_i, gpio_o, gpio_oe_o;
    logic        irq_o, dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    wb_gpio_slave #(.GPIO_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_we_i   (wb_we_i),
        .wb_sel_i  (wb_sel_i),
        .wb_stb_i  (wb_stb_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_ack_o  (wb_ack_o),
        .gpio_i    (gpio_i),
        .gpio_o    (gpio_o),
        .gpio_oe_o (gpio_oe_o),
        .irq_o     (irq_o),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [31:0] exp_o;
        logic [31:0] exp_oe;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge after the ack has cleared.
    task automatic xfer(input logic we_v, input logic [31:0] adr_v, input logic [31:0] dat_v,
                        input logic [3:0] sel_v, output logic [31:0] rd, output logic irq_ack);
        logic a0, a1, a2;
        a0       = wb_ack_o;
        wb_we_i  = we_v;
        wb_adr_i = adr_v;
        wb_dat_i = dat_v;
        wb_sel_i = sel_v;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        @(negedge clk);
        a1       = wb_ack_o;
        rd       = wb_dat_o;
        irq_ack  = irq_o;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        @(negedge clk);
        a2 = wb_ack_o;
        check("ack_before", 32'(a0), 32'd0);
        check("ack_one_cycle", 32'(a1), 32'd1);
        check("ack_released", 32'(a2), 32'd0);
        check("dat_idle_zero", wb_dat_o, 32'd0);
    endtask

    logic [31:0] rd;
    logic        irq_ack;

    initial begin
        vecs[0]  = '{1'b1, 32'h04, 32'hA5A5_0F0F, 4'b1111, 1'b0, 32'h0,         32'hA5A5_0F0F, 32'h0000_0000};
        vecs[1]  = '{1'b1, 32'h08, 32'hFFFF_0000, 4'b1111, 1'b0, 32'h0,         32'hA5A5_0F0F, 32'hFFFF_0000};
        vecs[2]  = '{1'b0, 32'h04, 32'h0,         4'b0000, 1'b1, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'hFFFF_0000};
        vecs[3]  = '{1'b0, 32'h08, 32'h0,         4'b0001, 1'b1, 32'hFFFF_0000, 32'hA5A5_0F0F, 32'hFFFF_0000};
        vecs[4]  = '{1'b1, 32'h04, 32'h1111_1111, 4'b1111, 1'b0, 32'h0,         32'h1111_1111, 32'hFFFF_0000};
        vecs[5]  = '{1'b1, 32'h04, 32'hFFFF_FFFF, 4'b0100, 1'b0, 32'h0,         32'h11FF_1111, 32'hFFFF_0000};
        vecs[6]  = '{1'b0, 32'h04, 32'h0,         4'b1111, 1'b1, 32'h11FF_1111, 32'h11FF_1111, 32'hFFFF_0000};
        vecs[7]  = '{1'b0, 32'h1C, 32'h0,         4'b1111, 1'b1, 32'h0,         32'h11FF_1111, 32'hFFFF_0000};
        vecs[8]  = '{1'b1, 32'h00, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'h0,         32'h11FF_1111, 32'hFFFF_0000};
        vecs[9]  = '{1'b0, 32'h00, 32'h0,         4'b1111, 1'b1, 32'h0,         32'h11FF_1111, 32'hFFFF_0000};
        vecs[10] = '{1'b1, 32'h0C, 32'h0000_00F0, 4'b0001, 1'b0, 32'h0,         32'h11FF_1111, 32'hFFFF_0000};
        vecs[11] = '{1'b0, 32'hFFFF_FF0C, 32'h0,      4'b0000, 1'b1, 32'h0000_00F0, 32'h11FF_1111, 32'hFFFF_0000};
        vecs[12] = '{1'b1, 32'h0C, 32'h0,         4'b1111, 1'b0, 32'h0,         32'h11FF_1111, 32'hFFFF_0000};
        vecs[13] = '{1'b0, 32'h10, 32'h0,         4'b1111, 1'b1, 32'h0,         32'h11FF_1111, 32'hFFFF_0000};
        vecs[14] = '{1'b1, 32'h24, 32'hDEAD_BEEF, 4'b1001, 1'b0, 32'h0,         32'hDEFF_11EF, 32'hFFFF_0000};
        vecs[15] = '{1'b0, 32'h04, 32'h0,         4'b1111, 1'b1, 32'hDEFF_11EF, 32'hDEFF_11EF, 32'hFFFF_0000};

        rst = 1'b1;
        wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0; wb_sel_i = '0;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; gpio_i = '0;
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_gpio_o", gpio_o, 32'd0);
        check("rst_gpio_oe", gpio_oe_o, 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd, irq_ack);
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_gpio_o", i), gpio_o, vecs[i].exp_o);
            check($sformatf("vec%0d_gpio_oe", i), gpio_oe_o, vecs[i].exp_oe);
            check($sformatf("vec%0d_irq", i), 32'(irq_o), 32'd0);
        end

        // Input synchronizer latency and edge capture on pin 3.
        gpio_i = 32'h8;
        xfer(1'b0, 32'h00, 32'h0, 4'hF, rd, irq_ack);
        check("in_too_early", rd, 32'h0);
        xfer(1'b0, 32'h00, 32'h0, 4'hF, rd, irq_ack);
        check("in_synced", rd, 32'h8);
        xfer(1'b0, 32'h10, 32'h0, 4'hF, rd, irq_ack);
        check("is_edge_set", rd, 32'h8);
        xfer(1'b1, 32'h0C, 32'h8, 4'hF, rd, irq_ack);
        check("irq_lag_after_ie", 32'(irq_ack), 32'd0);
        check("irq_after_ie", 32'(irq_o), 32'd1);

        // Clear of IS[3] on the same edge as a new rising edge: set wins.
        gpio_i = 32'h0;
        repeat (4) @(negedge clk);
        gpio_i = 32'h8;
        repeat (2) @(negedge clk);
        xfer(1'b1, 32'h10, 32'h8, 4'hF, rd, irq_ack);
        check("irq_race_ack", 32'(irq_ack), 32'd1);
        check("irq_race_after", 32'(irq_o), 32'd1);
        xfer(1'b0, 32'h10, 32'h0, 4'hF, rd, irq_ack);
        check("is_race_kept", rd, 32'h8);
        xfer(1'b1, 32'h10, 32'h8, 4'hF, rd, irq_ack);
        check("irq_clear_lag", 32'(irq_ack), 32'd1);
        check("irq_cleared", 32'(irq_o), 32'd0);
        xfer(1'b0, 32'h10, 32'h0, 4'hF, rd, irq_ack);
        check("is_cleared", rd, 32'h0);

        // Strobe held high for 3 cycles: ack pattern 0,1,0,1.
        wb_we_i = 1'b0; wb_adr_i = 32'h04; wb_sel_i = 4'hF;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        check("held_ack0", 32'(wb_ack_o), 32'd0);
        @(negedge clk);
        check("held_ack1", 32'(wb_ack_o), 32'd1);
        check("held_dat1", wb_dat_o, 32'hDEFF_11EF);
        @(negedge clk);
        check("held_ack2", 32'(wb_ack_o), 32'd0);
        @(negedge clk);
        check("held_ack3", 32'(wb_ack_o), 32'd1);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        @(negedge clk);
        check("held_ack4", 32'(wb_ack_o), 32'd0);

        // Reset asserted mid-acknowledge of an OUT write.
        wb_we_i = 1'b1; wb_adr_i = 32'h04; wb_dat_i = 32'h1234_5678; wb_sel_i = 4'hF;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        @(negedge clk);
        check("abort_ack_pre", 32'(wb_ack_o), 32'd1);
        check("abort_out_pre", gpio_o, 32'h1234_5678);
        #2 rst = 1'b1;
        #1;
        check("abort_ack", 32'(wb_ack_o), 32'd0);
        check("abort_out", gpio_o, 32'd0);
        check("abort_oe", gpio_oe_o, 32'd0);
        check("abort_state", 32'(dbg_state), 32'd0);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Pin 3 held high across release; first cycle accepts a request.
        xfer(1'b0, 32'h10, 32'h0, 4'hF, rd, irq_ack);
        check("post_rst_is_early", rd, 32'h0);
        repeat (2) @(negedge clk);
        xfer(1'b0, 32'h10, 32'h0, 4'hF, rd, irq_ack);
        check("post_rst_is_edge", rd, 32'h8);
        check("post_rst_irq", 32'(irq_o), 32'd0);
        xfer(1'b0, 32'h0C, 32'h0, 4'hF, rd, irq_ack);
        check("post_rst_ie", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
